pipe_route_stage: RTL

PIPE_ROUTE_STAGE -- requirements
Module: pipe_route_stage

---
 rtl/pipe_route_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_route_stage.sv
// Single-clock routing stage: a DEPTH-entry circular FIFO of {sel, data} whose head is offered
// to exactly one of NUM_OUT destinations. The optional same-cycle bypass is enabled by PIPE_ROUTE_BYPASS_EN.
module pipe_route_stage #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2,
  parameter int NUM_OUT = 2,
  localparam int SEL_W  = $clog2(NUM_OUT),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               err_sel
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SEL_W:0] NUM_OUT_W = NUM_OUT[SEL_W:0];
  localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

  logic [SEL_W-1:0]  sel_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_sel_q, err_sel_d;

  logic               head_valid;
  logic [SEL_W-1:0]   head_sel;
  logic               head_oob;
  logic [NUM_OUT-1:0] reg_valid;
  logic               pop;
  logic               push;
  logic               bypass;

  assign head_valid = (count_q != '0);
  assign head_sel   = sel_mem[rd_ptr_q];
  // An out-of-range head is never offered; it is discarded on the next edge instead.
  assign head_oob   = head_valid && ({1'b0, head_sel} >= NUM_OUT_W);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    reg_valid = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (head_valid && (head_sel == SEL_W'(k))) reg_valid[k] = 1'b1;
    end
  end

  assign pop = (|(reg_valid & out_ready)) || head_oob;

`ifdef PIPE_ROUTE_BYPASS_EN
  logic [NUM_OUT-1:0] in_hit;

  always_comb begin
    in_hit = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_valid && (in_sel == SEL_W'(k))) in_hit[k] = 1'b1;
    end
  end

  assign bypass    = !head_valid && !flush && (|(in_hit & out_ready));
  assign out_valid = bypass ? in_hit : reg_valid;
  assign out_data  = bypass ? in_data : data_mem[rd_ptr_q];
`else
  assign bypass    = 1'b0;
  assign out_valid = reg_valid;
  assign out_data  = data_mem[rd_ptr_q];
`endif

  assign in_ready = !flush && ((count_q < DEPTH_W) || pop);
  assign push     = in_valid && in_ready && !bypass;
  assign count    = count_q;
  assign err_sel  = err_sel_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_sel_d = err_sel_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_sel_d = 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (head_oob) err_sel_d = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_sel_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_sel_q <= err_sel_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_q]  <= in_sel;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

endmodule
